// File: rtl/ssio_calib_pkg.sv
// Shared definitions for the source-synchronous input delay calibration block:
// FSM state encoding and status vector bit positions.
package ssio_calib_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_FINAL  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_FAIL   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_LOAD   = S_LOAD,
        ST_SETTLE = S_SETTLE,
        ST_CHECK  = S_CHECK,
        ST_NEXT   = S_NEXT,
        ST_FINAL  = S_FINAL,
        ST_DONE   = S_DONE,
        ST_FAIL   = S_FAIL
    } calib_state_e;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_FAIL = 2;
    localparam int STAT_W    = 3;

endpackage

// File: rtl/ssio_calib_window.sv
// Tracks the current run of passing taps and the longest run seen so far.
// A run is closed on a failing tap or at the last tap; ties keep the earlier run.
module ssio_calib_window
    import ssio_calib_pkg::*;
#(
    parameter int TAP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic             pass,
    input  logic             last,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] win_start,
    output logic [TAP_W:0]   win_len
);

    logic [TAP_W-1:0] run_start_q, run_start_d, best_start_q, best_start_d;
    logic [TAP_W:0]   run_len_q, run_len_d, best_len_q, best_len_d;
    logic [TAP_W-1:0] cand_start;
    logic [TAP_W:0]   cand_len;

    always_comb begin
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        cand_start   = run_start_q;
        cand_len     = run_len_q;
        if (clear) begin
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (step) begin
            if (pass) begin
                cand_start  = (run_len_q == '0) ? tap : run_start_q;
                cand_len    = run_len_q + 1'b1;
                run_start_d = cand_start;
                run_len_d   = cand_len;
            end
            // The sweep does not wrap, so the last tap always closes the run.
            if (!pass || last) begin
                run_len_d = '0;
                if (cand_len > best_len_q) begin
                    best_start_d = cand_start;
                    best_len_d   = cand_len;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign win_start = best_start_q;
    assign win_len   = best_len_q;

endmodule

// File: rtl/ssio_delay_calib.sv
// Sweeps input delay taps, checks a fixed DDR training pattern per tap and loads
// the centre of the widest passing window. Option: SSIO_DELAY_CALIB_PERIODIC_EN.
module ssio_delay_calib
    import ssio_calib_pkg::*;
#(
`ifdef SSIO_DELAY_CALIB_PERIODIC_EN
    parameter int               RECAL_CYCLES  = 1 << 20,
`endif
    parameter int               WIDTH         = 5,
    parameter int               TAP_W         = 5,
    parameter int               SETTLE_CYCLES = 16,
    parameter int               CHECK_CYCLES  = 64,
    parameter logic [WIDTH-1:0] PATTERN_Q1    = 5'h15,
    parameter logic [WIDTH-1:0] PATTERN_Q2    = 5'h15,
    parameter int               MIN_WINDOW    = 4,
    parameter int               DEFAULT_TAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] input_q1,
    input  logic [WIDTH-1:0] input_q2,
    output logic             delay_ld,
    output logic [TAP_W-1:0] delay_value,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [TAP_W-1:0] win_start,
    output logic [TAP_W:0]   win_len
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    calib_state_e     state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mism_q, mism_d;
    logic [TAP_W-1:0] hold_q, hold_d;
    logic             ld;
    logic [TAP_W-1:0] ld_val;
    logic             win_clear, win_step, tap_last, go;
    logic [TAP_W:0]   half_len;
    logic [STAT_W-1:0] status;

`ifdef SSIO_DELAY_CALIB_PERIODIC_EN
    localparam int RCW = (RECAL_CYCLES > 1) ? $clog2(RECAL_CYCLES) : 1;
    logic [RCW-1:0] recal_q, recal_d;
    logic           recal_fire;

    always_comb begin
        recal_d    = '0;
        recal_fire = 1'b0;
        // Counting only while parked; any other state (incl. FINAL) clears it.
        if (state_q == ST_DONE || state_q == ST_FAIL) begin
            recal_fire = (recal_q == RCW'(RECAL_CYCLES - 1));
            recal_d    = recal_fire ? '0 : recal_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) recal_q <= '0;
        else     recal_q <= recal_d;
    end

    assign go = start | recal_fire;
`else
    assign go = start;
`endif

    assign tap_last = (tap_q == '1);
    assign half_len = (win_len - 1'b1) >> 1;

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        cnt_d     = cnt_q;
        mism_d    = mism_q;
        ld        = 1'b0;
        ld_val    = hold_q;
        win_clear = 1'b0;
        win_step  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (go) begin
                    tap_d     = '0;
                    cnt_d     = '0;
                    win_clear = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld      = 1'b1;
                ld_val  = tap_q;
                mism_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (input_q1 != PATTERN_Q1 || input_q2 != PATTERN_Q2) mism_d = 1'b1;
                if (cnt_q == CNT_W'(CHECK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_NEXT: begin
                win_step = 1'b1;
                if (tap_last) begin
                    state_d = ST_FINAL;
                end else begin
                    tap_d   = tap_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_FINAL: begin
                ld = 1'b1;
                if (win_len >= (TAP_W+1)'(MIN_WINDOW)) begin
                    ld_val  = win_start + half_len[TAP_W-1:0];
                    state_d = ST_DONE;
                end else begin
                    ld_val  = TAP_W'(DEFAULT_TAP);
                    state_d = ST_FAIL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        hold_d = ld ? ld_val : hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tap_q   <= '0;
            cnt_q   <= '0;
            mism_q  <= 1'b0;
            hold_q  <= TAP_W'(DEFAULT_TAP);
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
            mism_q  <= mism_d;
            hold_q  <= hold_d;
        end
    end

    ssio_calib_window #(.TAP_W(TAP_W)) u_window (
        .clk       (clk),
        .rst       (rst),
        .clear     (win_clear),
        .step      (win_step),
        .pass      (!mism_q),
        .last      (tap_last),
        .tap       (tap_q),
        .win_start (win_start),
        .win_len   (win_len)
    );

    always_comb begin
        status = '0;
        case (state_q)
            ST_IDLE: status = '0;
            ST_DONE: status[STAT_DONE] = 1'b1;
            ST_FAIL: status[STAT_FAIL] = 1'b1;
            default: status[STAT_BUSY] = 1'b1;
        endcase
    end

    assign busy        = status[STAT_BUSY];
    assign done        = status[STAT_DONE];
    assign fail        = status[STAT_FAIL];
    assign delay_ld    = ld;
    assign delay_value = ld_val;

endmodule

// File: doc/ssio_delay_calib.md
SSIO_DELAY_CALIB -- requirements
Module: ssio_delay_calib

Interface
Parameters, one per line: name, default, meaning.
REQ-001 WIDTH, 5, number of DDR data lanes checked (RGMII: 4 data + ctl).
REQ-002 TAP_W, 5, delay tap code width; the sweep covers 2^TAP_W taps.
REQ-003 SETTLE_CYCLES, 16, wait cycles after each tap load before checking.
REQ-004 CHECK_CYCLES, 64, compare cycles per tap.
REQ-005 PATTERN_Q1 / PATTERN_Q2, 5'h15 / 5'h15, expected rising/falling-edge samples.
REQ-006 MIN_WINDOW, 4, minimum passing run length for success.
REQ-007 DEFAULT_TAP, 0, tap loaded on failure.

Ports, one per line: name, direction, width, meaning.
REQ-008 clk, in, 1, the single clock (recovered input clock domain).
REQ-009 rst, in, 1, asynchronous active-high reset.
REQ-010 start, in, 1, single-cycle pulse that requests a calibration sweep.
REQ-011 input_q1 / input_q2, in, WIDTH each, rising/falling samples from the DDR input datapath.
REQ-012 delay_ld, out, 1, single-cycle load strobe to the input delay elements.
REQ-013 delay_value, out, TAP_W, tap code; valid whenever delay_ld=1 and held between loads.
REQ-014 busy / done / fail, out, 1 each, status outputs.
REQ-015 win_start / win_len, out, TAP_W / TAP_W+1, best passing window found.

Function
REQ-016 FSM states: IDLE, LOAD, SETTLE, CHECK, NEXT, FINAL, DONE, FAIL.
REQ-017 IDLE/DONE/FAIL plus start=1: tap:=0, clear the window trackers, clear done/fail, go to LOAD.
REQ-018 LOAD (1 cycle): delay_ld=1, delay_value=tap; then go to SETTLE.
REQ-019 SETTLE: count SETTLE_CYCLES cycles, then go to CHECK.
REQ-020 CHECK: count CHECK_CYCLES cycles. The tap passes only if every cycle has input_q1==PATTERN_Q1 and input_q2==PATTERN_Q2 on all bits; a single mismatch fails the tap.
REQ-021 NEXT (1 cycle) on a pass: extend the current run, or start a new run at tap.
REQ-022 NEXT (1 cycle) on a fail: close the current run.
REQ-023 A closed run replaces the best window only if it is strictly longer, so the first-found window wins ties.
REQ-024 NEXT at tap=2^TAP_W-1: close any open run (no wrap-around to tap 0), go to FINAL. Otherwise tap:=tap+1 and go to LOAD.
REQ-025 FINAL (1 cycle) when win_len>=MIN_WINDOW: delay_ld=1, delay_value=win_start+((win_len-1)>>1) (floor centre), go to DONE.
REQ-026 FINAL (1 cycle) when win_len<MIN_WINDOW: delay_ld=1, delay_value=DEFAULT_TAP, go to FAIL.
REQ-027 busy=1 in every state except IDLE, DONE and FAIL; start is ignored while busy=1.
REQ-028 done=1 only in DONE; fail=1 only in FAIL; both are held until the next start.
REQ-029 Latency from start to done/fail is 2^TAP_W*(SETTLE_CYCLES+CHECK_CYCLES+2)+1 cycles, exactly.
REQ-030 Run and window lengths are TAP_W+1 bits wide, so a full 2^TAP_W pass must not overflow.

Reset
REQ-031 rst asserted, including mid-sweep: state=IDLE, tap=0, delay_ld=0, delay_value=DEFAULT_TAP, busy=0, done=0, fail=0, win_start=0, win_len=0, all counters 0.
REQ-032 No delay_ld pulse is issued on reset release.

Configuration
REQ-033 Macro SSIO_DELAY_CALIB_PERIODIC_EN: when defined, a RECAL_CYCLES (parameter, default 2^20) counter runs in DONE and FAIL and self-issues start when it expires; the counter is cleared on every entry to DONE or FAIL.
REQ-034 When the macro is undefined, the counter logic is absent and recalibration occurs only on external start.

Structure
REQ-035 Shared package ssio_calib_pkg holds the state encoding localparams and the status bit constants.
REQ-036 The run/best-window tracking is a sub-module, ssio_calib_window; the FSM, counters and delay interface stay in ssio_delay_calib.

Verification
(TAP_W=5, SETTLE_CYCLES=16, CHECK_CYCLES=64, MIN_WINDOW=4 unless stated.)
REQ-037 Pattern matches on taps 10..19 only -> done=1, win_start=10, win_len=10, final delay_value=14, latency 2625 cycles.
REQ-038 Windows 3..5 and 20..27 -> win_start=20, win_len=8, final delay_value=23.
REQ-039 Window 10..19 with one mismatch at tap 12, cycle 30 -> win_start=13, win_len=7, final delay_value=16.
REQ-040 No tap passes -> fail=1, final delay_ld with delay_value=0, done=0.
REQ-041 All 32 taps pass -> win_len=32 with no overflow, delay_value=15; a start pulse during busy changes nothing.
REQ-042 rst pulse at tap 7 during CHECK -> all outputs at reset values, no further delay_ld; a later start restarts the sweep at tap 0.
